// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a chain of
// full-adder cells, carry registered between digits, one-cycle done pulse.

// Single-bit full-adder cell.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (y & ci) | (ci & x);
endmodule

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int RSW  = WIDTH - DIGIT;  // completed digits held before the last one

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   cc;
  logic [WIDTH-1:0] res_full;
  logic             run, last;

  assign run  = (state_q == RUN);
  assign last = run && (cnt_q == CW'(NDIG - 1));

  // Carry chain for one digit; cc[i] is the carry into bit i of the digit.
  assign cc[0] = carry_q;
  fa_cell u_fa [DIGIT-1:0] (
    .x  (sa_q[DIGIT-1:0]),
    .y  (sb_q[DIGIT-1:0]),
    .ci (cc[DIGIT-1:0]),
    .s  (dsum),
    .co (cc[DIGIT:1])
  );

  // Result register: earlier digits fill from the top; the final digit is
  // combined directly so the completion edge sees the whole word.
  if (RSW == 0) begin : g_rs_none
    assign res_full = dsum;
  end else begin : g_rs
    logic [RSW-1:0] rs_q, rs_d;
    if (RSW == DIGIT) begin : g_one
      // Single stored digit: simply reload it each RUN cycle.
      always_comb rs_d = run ? dsum : rs_q;
    end else begin : g_many
      // Shift the new digit in at the top.
      always_comb rs_d = run ? {dsum, rs_q[RSW-1:DIGIT]} : rs_q;
    end
    // Completed-digit storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rs_q <= '0;
      else        rs_q <= rs_d;
    end
    assign res_full = {dsum, rs_q};
  end

  // Next-state and datapath updates for IDLE/RUN/DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          sa_d    = bus.a;
          sb_d    = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        sa_d    = sa_q >> DIGIT;
        sb_d    = sb_q >> DIGIT;
        carry_d = cc[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = res_full;
          cout_d  = cc[DIGIT];
          ovf_d   = cc[DIGIT-1] ^ cc[DIGIT];
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases on (8,1)/(8,4), then randomized
// operations on five configurations in parallel against an arithmetic model.
module tb_serial_addsub;
  localparam int N = 5;
  localparam int W [N]  = '{8, 8, 16, 8, 8};
  localparam int ND [N] = '{8, 4, 4, 1, 2};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] ta [N], tb_ [N];
  logic        tsub [N], tstart [N];
  logic [15:0] o_sum [N];
  logic        o_busy [N], o_done [N], o_cout [N], o_ovf [N];
  logic [15:0] last [N];

  int ncmp = 0;
  int nerr = 0;

  serial_addsub_if #(.WIDTH(8))  bus0 ();
  serial_addsub_if #(.WIDTH(8))  bus1 ();
  serial_addsub_if #(.WIDTH(16)) bus2 ();
  serial_addsub_if #(.WIDTH(8))  bus3 ();
  serial_addsub_if #(.WIDTH(8))  bus4 ();

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_addsub #(.WIDTH(8),  .DIGIT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  serial_addsub #(.WIDTH(8),  .DIGIT(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  serial_addsub #(.WIDTH(8),  .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus0.start = tstart[0]; assign bus0.sub = tsub[0]; assign bus0.a = ta[0][7:0]; assign bus0.b = tb_[0][7:0];
  assign bus1.start = tstart[1]; assign bus1.sub = tsub[1]; assign bus1.a = ta[1][7:0]; assign bus1.b = tb_[1][7:0];
  assign bus2.start = tstart[2]; assign bus2.sub = tsub[2]; assign bus2.a = ta[2];      assign bus2.b = tb_[2];
  assign bus3.start = tstart[3]; assign bus3.sub = tsub[3]; assign bus3.a = ta[3][7:0]; assign bus3.b = tb_[3][7:0];
  assign bus4.start = tstart[4]; assign bus4.sub = tsub[4]; assign bus4.a = ta[4][7:0]; assign bus4.b = tb_[4][7:0];

  assign o_sum[0] = {8'h00, bus0.sum}; assign o_busy[0] = bus0.busy; assign o_done[0] = bus0.done; assign o_cout[0] = bus0.cout; assign o_ovf[0] = bus0.ovf;
  assign o_sum[1] = {8'h00, bus1.sum}; assign o_busy[1] = bus1.busy; assign o_done[1] = bus1.done; assign o_cout[1] = bus1.cout; assign o_ovf[1] = bus1.ovf;
  assign o_sum[2] = bus2.sum;          assign o_busy[2] = bus2.busy; assign o_done[2] = bus2.done; assign o_cout[2] = bus2.cout; assign o_ovf[2] = bus2.ovf;
  assign o_sum[3] = {8'h00, bus3.sum}; assign o_busy[3] = bus3.busy; assign o_done[3] = bus3.done; assign o_cout[3] = bus3.cout; assign o_ovf[3] = bus3.ovf;
  assign o_sum[4] = {8'h00, bus4.sum}; assign o_busy[4] = bus4.busy; assign o_done[4] = bus4.done; assign o_cout[4] = bus4.cout; assign o_ovf[4] = bus4.ovf;

  // Reference: plain integer arithmetic on the w-bit operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic sub, output logic [15:0] s,
                                output logic co, output logic ov);
    longint m, ua, ub, r, sa, sb, sr;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    if (sub) begin r = ua - ub; co = (ua >= ub); end
    else     begin r = ua + ub; co = (r >= m);   end
    s  = 16'(r & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sub ? sa - sb : sa + sb;
    ov = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
    ta[i] = a; tb_[i] = b; tsub[i] = sub; tstart[i] = 1'b1;
    @(negedge clk);
    tstart[i] = 1'b0;
    ta[i] = 16'($urandom); tb_[i] = 16'($urandom); tsub[i] = 1'($urandom);
  endtask

  // Checks busy/hold through RUN, then the done cycle; returns at the done negedge.
  task automatic finish_op(input int i, input logic [15:0] es, input logic ec, input logic eo,
                           input bit noise);
    for (int j = 0; j < ND[i]; j++) begin
      chk("run busy", {15'd0, o_busy[i]}, 16'd1);
      chk("run done", {15'd0, o_done[i]}, 16'd0);
      chk("run hold sum", o_sum[i], last[i]);
      if (noise && (j == 2 || j == 4)) begin
        ta[i] = 16'h00F0; tb_[i] = 16'h000F; tsub[i] = 1'b1; tstart[i] = 1'b1;
      end else tstart[i] = 1'b0;
      @(negedge clk);
    end
    tstart[i] = 1'b0;
    chk("done", {15'd0, o_done[i]}, 16'd1);
    chk("done busy", {15'd0, o_busy[i]}, 16'd0);
    chk("sum", o_sum[i], es);
    chk("cout", {15'd0, o_cout[i]}, {15'd0, ec});
    chk("ovf", {15'd0, o_ovf[i]}, {15'd0, eo});
    last[i] = es;
  endtask

  initial begin
    logic [15:0] rs [N], ra [N], rb [N];
    logic        rc [N], ro [N], rsub [N];
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0; tb_[i] = '0; tsub[i] = 1'b0; tstart[i] = 1'b0; last[i] = '0;
    end
    #12;
    chk("reset busy", {15'd0, o_busy[0]}, 16'd0);
    chk("reset done", {15'd0, o_done[0]}, 16'd0);
    chk("reset sum",  o_sum[0], 16'd0);
    chk("reset cout", {15'd0, o_cout[0]}, 16'd0);
    chk("reset ovf",  {15'd0, o_ovf[0]}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_start(0, 16'h3C, 16'h5A, 1'b0); finish_op(0, 16'h96, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk("done drops", {15'd0, o_done[0]}, 16'd0);
    do_start(0, 16'hFF, 16'h01, 1'b0); finish_op(0, 16'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_start(0, 16'h10, 16'h20, 1'b1); finish_op(0, 16'hF0, 1'b0, 1'b0, 1'b0);
    // Back-to-back: start presented during the done cycle.
    do_start(0, 16'h80, 16'h01, 1'b1); finish_op(0, 16'h7F, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    // Start pulses during RUN must be ignored.
    do_start(0, 16'h21, 16'h12, 1'b0); finish_op(0, 16'h33, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    do_start(4, 16'hA7, 16'h6E, 1'b0); finish_op(4, 16'h15, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    do_start(0, 16'h55, 16'hAA, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset busy", {15'd0, o_busy[0]}, 16'd0);
    chk("mid-reset done", {15'd0, o_done[0]}, 16'd0);
    chk("mid-reset sum",  o_sum[0], 16'd0);
    chk("mid-reset cout", {15'd0, o_cout[0]}, 16'd0);
    chk("mid-reset ovf",  {15'd0, o_ovf[0]}, 16'd0);
    for (int i = 0; i < N; i++) last[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      chk("post-reset done", {15'd0, o_done[0]}, 16'd0);
      chk("post-reset busy", {15'd0, o_busy[0]}, 16'd0);
      @(negedge clk);
    end

    // Random regression: all five configurations started together each op.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = 16'($urandom); rb[i] = 16'($urandom); rsub[i] = 1'($urandom);
        model(W[i], ra[i], rb[i], rsub[i], rs[i], rc[i], ro[i]);
        ta[i] = ra[i]; tb_[i] = rb[i]; tsub[i] = rsub[i]; tstart[i] = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        tstart[i] = 1'b0; ta[i] = 16'($urandom); tb_[i] = 16'($urandom);
      end
      for (int c = 0; c <= 8; c++) begin
        for (int i = 0; i < N; i++) begin
          if (c < ND[i]) begin
            chk($sformatf("rnd%0d busy", i), {15'd0, o_busy[i]}, 16'd1);
            chk($sformatf("rnd%0d early done", i), {15'd0, o_done[i]}, 16'd0);
            chk($sformatf("rnd%0d hold", i), o_sum[i], last[i]);
          end else if (c == ND[i]) begin
            chk($sformatf("rnd%0d done", i), {15'd0, o_done[i]}, 16'd1);
            chk($sformatf("rnd%0d sum a=%0h b=%0h sub=%0d", i, ra[i], rb[i], rsub[i]), o_sum[i], rs[i]);
            chk($sformatf("rnd%0d cout", i), {15'd0, o_cout[i]}, {15'd0, rc[i]});
            chk($sformatf("rnd%0d ovf", i), {15'd0, o_ovf[i]}, {15'd0, ro[i]});
            last[i] = rs[i];
          end else begin
            chk($sformatf("rnd%0d idle done", i), {15'd0, o_done[i]}, 16'd0);
            chk($sformatf("rnd%0d idle sum", i), o_sum[i], last[i]);
          end
        end
        if (c < 8) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
